// File: rtl/xfill_pattern_applier.sv
// ATPG pattern applicator: fills X input bits by policy, drives the DUT inputs, strobes masked outputs.
// Optional response MISR on the signature output is built only when XFILL_MISR_EN is defined.
module xfill_pattern_applier #(
    parameter int NINPUTS  = 5,
    parameter int NOUTPUTS = 2,
    parameter int SETTLE   = 2,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [1:0]          fill_mode,
    input  logic                pat_valid,
    output logic                pat_ready,
    input  logic [NINPUTS-1:0]  pat_value,
    input  logic [NINPUTS-1:0]  pat_care,
    input  logic [NOUTPUTS-1:0] pat_xpct,
    input  logic [NOUTPUTS-1:0] pat_mask,
    output logic [NINPUTS-1:0]  pi,
    input  logic [NOUTPUTS-1:0] po,
    output logic                result_valid,
    output logic                result_fail,
    output logic                error_sticky,
    output logic [CNT_W-1:0]    fail_count,
    output logic [CNT_W-1:0]    pat_count,
    output logic [CNT_W-1:0]    toggle_count,
    output logic [15:0]         signature
);

    localparam int SC_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int PC_W  = $clog2(NINPUTS + 1);
    localparam int SUM_W = CNT_W + PC_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_IDLE, S_SETTLE} state_t;

    state_t                state_q, state_d;
    logic [SC_W-1:0]       settle_cnt_q, settle_cnt_d;
    logic [NINPUTS-1:0]    pi_q, pi_d;
    logic [NOUTPUTS-1:0]   xpct_q, xpct_d;
    logic [NOUTPUTS-1:0]   mask_q, mask_d;
    logic                  result_valid_q, result_valid_d;
    logic                  result_fail_q, result_fail_d;
    logic                  error_q, error_d;
    logic [CNT_W-1:0]      fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0]      pat_cnt_q, pat_cnt_d;
    logic [CNT_W-1:0]      tog_cnt_q, tog_cnt_d;

    logic                  accept;
    logic                  strobe;
    logic                  fail;
    logic [NINPUTS-1:0]    fill_vec;
    logic [NINPUTS-1:0]    pi_new;
    logic [NINPUTS-1:0]    toggles;
    logic [PC_W-1:0]       pop;
    logic [SUM_W-1:0]      tog_sum;
    logic [CNT_W-1:0]      tog_sat;

    assign accept = pat_valid && (state_q == S_IDLE);
    assign strobe = (state_q == S_SETTLE) && (settle_cnt_q == '0);
    assign fail   = |((po ^ xpct_q) & mask_q);

    always_comb begin
        fill_vec = '0;
        case (fill_mode)
            2'b01:   fill_vec = '1;
            2'b10:   fill_vec = pi_q;
            default: fill_vec = '0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NINPUTS; gi++) begin : g_fill
            assign pi_new[gi]  = pat_care[gi] ? pat_value[gi] : fill_vec[gi];
            assign toggles[gi] = pi_new[gi] ^ pi_q[gi];
        end
    endgenerate

    always_comb begin
        pop = '0;
        for (int i = 0; i < NINPUTS; i++) begin
            pop = pop + PC_W'(toggles[i]);
        end
    end

    // Toggle sum is formed wide so the clamp sees the true total.
    assign tog_sum = SUM_W'(tog_cnt_q) + SUM_W'(pop);
    assign tog_sat = (tog_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : tog_sum[CNT_W-1:0];

    always_comb begin
        state_d        = state_q;
        settle_cnt_d   = settle_cnt_q;
        pi_d           = pi_q;
        xpct_d         = xpct_q;
        mask_d         = mask_q;
        result_valid_d = 1'b0;
        result_fail_d  = result_fail_q;
        error_d        = error_q;
        fail_cnt_d     = fail_cnt_q;
        pat_cnt_d      = pat_cnt_q;
        tog_cnt_d      = tog_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d      = S_SETTLE;
                    settle_cnt_d = SC_W'(SETTLE - 1);
                    pi_d         = pi_new;
                    xpct_d       = pat_xpct;
                    mask_d       = pat_mask;
                    tog_cnt_d    = tog_sat;
                end
            end
            S_SETTLE: begin
                if (strobe) begin
                    state_d        = S_IDLE;
                    result_valid_d = 1'b1;
                    result_fail_d  = fail;
                    error_d        = error_q | fail;
                    if (pat_cnt_q != CNT_MAX) pat_cnt_d = pat_cnt_q + CNT_W'(1);
                    if (fail && (fail_cnt_q != CNT_MAX)) fail_cnt_d = fail_cnt_q + CNT_W'(1);
                end else begin
                    settle_cnt_d = settle_cnt_q - SC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Clear overrides any same-cycle update; the result pulse itself still goes out.
        if (clr) begin
            error_d    = 1'b0;
            fail_cnt_d = '0;
            pat_cnt_d  = '0;
            tog_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            settle_cnt_q   <= '0;
            pi_q           <= '0;
            xpct_q         <= '0;
            mask_q         <= '0;
            result_valid_q <= 1'b0;
            result_fail_q  <= 1'b0;
            error_q        <= 1'b0;
            fail_cnt_q     <= '0;
            pat_cnt_q      <= '0;
            tog_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            settle_cnt_q   <= settle_cnt_d;
            pi_q           <= pi_d;
            xpct_q         <= xpct_d;
            mask_q         <= mask_d;
            result_valid_q <= result_valid_d;
            result_fail_q  <= result_fail_d;
            error_q        <= error_d;
            fail_cnt_q     <= fail_cnt_d;
            pat_cnt_q      <= pat_cnt_d;
            tog_cnt_q      <= tog_cnt_d;
        end
    end

`ifdef XFILL_MISR_EN
    logic [15:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (strobe) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ 16'(po & mask_q);
        end
        if (clr) sig_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= '0;
        else        sig_q <= sig_d;
    end

    assign signature = sig_q;
`else
    assign signature = 16'h0000;
`endif

    assign pat_ready    = (state_q == S_IDLE);
    assign pi           = pi_q;
    assign result_valid = result_valid_q;
    assign result_fail  = result_fail_q;
    assign error_sticky = error_q;
    assign fail_count   = fail_cnt_q;
    assign pat_count    = pat_cnt_q;
    assign toggle_count = tog_cnt_q;

endmodule
